alu: RTL and testbench
======================

ALU -- requirements
Module: alu

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: clk and rst_n.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-004 A  input  32  first operand, unsigned.
REQ-005 B  input  32  second operand, unsigned; shift amount for shift ops.
REQ-006 operatie  input  4  operation select.
REQ-007 rezultat  output  32  registered primary result.
REQ-008 rest_rezultat  output  32  registered division remainder.
REQ-009 zero  output  1  registered flag; 1 when rezultat is zero.

Function
REQ-010 All arithmetic SHALL be unsigned 32-bit; results wrap modulo 2^32; no carry, overflow or sign outputs.
REQ-011 Op encoding SHALL be: 0 ADD A+B; 1 SUB A-B; 2 MUL low 32 bits of A*B; 3 DIV quotient A/B; 4 AND; 5 OR; 6 XOR; 7 SHL A<<B; 8 SHR logical A>>B.
REQ-012 Codes 9-15 SHALL produce rezultat=0 and rest_rezultat=0.
REQ-013 For op 3, rest_rezultat SHALL be A mod B; for all other ops rest_rezultat SHALL be 0.
REQ-014 Division by zero SHALL give rezultat=32'hFFFF_FFFF and rest_rezultat=A.
REQ-015 Shifts SHALL use the full B value; B >= 32 SHALL give rezultat=0; vacated bits are filled with 0.
REQ-016 SUB with A < B SHALL wrap, e.g. 3-5 = 32'hFFFF_FFFE.
REQ-017 Outputs SHALL update on every rising clk edge when rst_n=1; latency is exactly 1 cycle from inputs to outputs.
REQ-018 There SHALL be no handshake; a new operation is accepted every cycle.
REQ-019 zero SHALL equal (next rezultat == 0) and be registered in the same cycle as rezultat. It depends only on rezultat, never on rest_rezultat.
REQ-020 The result computation SHALL be combinational from A, B and operatie, followed by one register stage. DIV SHALL complete within the single cycle.

Reset
REQ-021 While rst_n=0 at a rising clk edge, rezultat and rest_rezultat SHALL be 0 and zero SHALL be 1.
REQ-022 Reset SHALL override any operation in the same cycle.
REQ-023 The first result after rst_n returns to 1 SHALL appear at the first rising edge with rst_n=1, reflecting the inputs sampled at that edge.
REQ-024 The block SHALL hold no other state.

Verification
REQ-025 Reset check: rst_n=0 for 2 cycles with A=7, B=3, op=0 -> rezultat=0, rest_rezultat=0, zero=1.
REQ-026 Basic ops, A=100, B=7 -> op0=107, op1=93, op2=700, op3=14 with rest=2, op4=4, op5=103, op6=99; zero=0 in every case.
REQ-027 Shifts and zero flag:
- A=50, B=3, op7 -> 400; op8 -> 6.
- A=5, B=5, op1 -> 0 with zero=1.
- A=1, B=32, op7 -> 0 with zero=1.
REQ-028 Boundary values:
- A=3, B=5, op1 -> 32'hFFFF_FFFE.
- A=32'hFFFF_FFFF, B=1, op0 -> 0 with zero=1.
- A=9, B=0, op3 -> rezultat=32'hFFFF_FFFF, rest=9.
REQ-029 Undefined op and latency:
- op=12 with A=10, B=2 -> rezultat=0, rest=0, zero=1.
- Changing inputs each cycle -> each output matches the prior cycle's inputs exactly (1-cycle latency).
REQ-030 Randomized check: A and B in 1..100 with A >= B, all ops 0-8, shift amount 1..3 -> outputs match a reference model every cycle.

Source files
------------

// File: rtl/alu.sv
// -----------------------------------------------------------------------------
// alu -- single-stage 32-bit unsigned arithmetic/logic unit.
//
// The result is computed combinationally from A, B and operatie and captured
// in one register stage, so every output reflects the inputs sampled at the
// previous rising clock edge. A new operation is accepted on every cycle and
// there is no handshake.
//
// Ports:
//   clk            in   1   rising-edge clock
//   rst_n          in   1   synchronous active-low reset
//   A              in  32   first operand (unsigned)
//   B              in  32   second operand (unsigned); shift amount for shifts
//   operatie       in   4   operation select:
//                           0 ADD, 1 SUB, 2 MUL (low 32 bits), 3 DIV,
//                           4 AND, 5 OR, 6 XOR, 7 SHL, 8 SHR (logical),
//                           9-15 produce all-zero results
//   rezultat       out 32   registered primary result
//   rest_rezultat  out 32   registered remainder (DIV only, else 0)
//   zero           out  1   registered flag, 1 when rezultat is zero
// -----------------------------------------------------------------------------
module alu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  operatie,
  output logic [31:0] rezultat,
  output logic [31:0] rest_rezultat,
  output logic        zero
);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_SHL = 4'd7;
  localparam logic [3:0] OP_SHR = 4'd8;

  logic [31:0] rezultat_d;
  logic [31:0] rezultat_q;
  logic [31:0] rest_rezultat_d;
  logic [31:0] rest_rezultat_q;
  logic        zero_d;
  logic        zero_q;

  // Next-result computation for the selected operation.
  always_comb begin
    rezultat_d      = 32'd0;
    rest_rezultat_d = 32'd0;
    case (operatie)
      OP_ADD: rezultat_d = A + B;
      OP_SUB: rezultat_d = A - B;
      // Only the low 32 bits of the product are kept.
      OP_MUL: rezultat_d = A * B;
      OP_DIV: begin
        // Divide by zero: saturated quotient, dividend passed through as remainder.
        if (B == 32'd0) begin
          rezultat_d      = 32'hFFFF_FFFF;
          rest_rezultat_d = A;
        end else begin
          rezultat_d      = A / B;
          rest_rezultat_d = A % B;
        end
      end
      OP_AND: rezultat_d = A & B;
      OP_OR:  rezultat_d = A | B;
      OP_XOR: rezultat_d = A ^ B;
      OP_SHL: begin
        // The full B is the shift amount; anything >= 32 shifts every bit out.
        if (B >= 32'd32) begin
          rezultat_d = 32'd0;
        end else begin
          rezultat_d = A << B[4:0];
        end
      end
      OP_SHR: begin
        if (B >= 32'd32) begin
          rezultat_d = 32'd0;
        end else begin
          rezultat_d = A >> B[4:0];
        end
      end
      default: begin
        rezultat_d      = 32'd0;
        rest_rezultat_d = 32'd0;
      end
    endcase
    // Flag follows the primary result only, never the remainder.
    zero_d = (rezultat_d == 32'd0);
  end

  // Output register stage with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rezultat_q      <= 32'd0;
      rest_rezultat_q <= 32'd0;
      zero_q          <= 1'b1;
    end else begin
      rezultat_q      <= rezultat_d;
      rest_rezultat_q <= rest_rezultat_d;
      zero_q          <= zero_d;
    end
  end

  assign rezultat      = rezultat_q;
  assign rest_rezultat = rest_rezultat_q;
  assign zero          = zero_q;

endmodule

// File: tb/tb_alu.sv
// -----------------------------------------------------------------------------
// tb_alu -- scoreboard bench for alu.
// Stimulus is driven on the falling edge and its expected response queued;
// a monitor pops one entry per rising edge and compares the registered outputs.
// Directed cases carry hand-derived constants; random cases use a reference
// model written with plain 64-bit arithmetic.
// -----------------------------------------------------------------------------
module tb_alu;

  logic        clk;
  logic        rst_n;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  operatie;
  logic [31:0] rezultat;
  logic [31:0] rest_rezultat;
  logic        zero;

  typedef struct {
    string       tag;
    logic [31:0] r;
    logic [31:0] rest;
    logic        z;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   failures;
  bit   stim_done;

  alu dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .A            (A),
    .B            (B),
    .operatie     (operatie),
    .rezultat     (rezultat),
    .rest_rezultat(rest_rezultat),
    .zero         (zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model built from the arithmetic rules, using 64-bit math.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input int op);
    exp_t        e;
    longint unsigned la, lb, m;
    la = {32'd0, a};
    lb = {32'd0, b};
    m  = 64'h1_0000_0000;
    e.tag = $sformatf("rand op%0d a=%0d b=%0d", op, a, b);
    e.rest = 32'd0;
    case (op)
      0: e.r = 32'((la + lb) % m);
      1: e.r = 32'((la + m - lb) % m);
      2: e.r = 32'((la * lb) % m);
      3: begin
        if (lb == 64'd0) begin
          e.r = 32'hFFFF_FFFF;
          e.rest = a;
        end else begin
          e.r = 32'(la / lb);
          e.rest = 32'(la % lb);
        end
      end
      4: e.r = a & b;
      5: e.r = a | b;
      6: e.r = a ^ b;
      7: e.r = (lb >= 64'd32) ? 32'd0 : 32'((la * (64'd1 << lb)) % m);
      8: e.r = (lb >= 64'd32) ? 32'd0 : 32'(la / (64'd1 << lb));
      default: e.r = 32'd0;
    endcase
    e.z = (e.r == 32'd0);
    return e;
  endfunction

  task automatic issue(input string tag, input logic rst, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] op,
                       input logic [31:0] er, input logic [31:0] erest,
                       input logic ez);
    exp_t e;
    @(negedge clk);
    rst_n    = rst;
    A        = a;
    B        = b;
    operatie = op;
    e.tag  = tag;
    e.r    = er;
    e.rest = erest;
    e.z    = ez;
    exp_q.push_back(e);
  endtask

  task automatic issue_model(input logic [31:0] a, input logic [31:0] b, input int op);
    exp_t e;
    e = model(a, b, op);
    issue(e.tag, 1'b1, a, b, 4'(op), e.r, e.rest, e.z);
  endtask

  // Monitor: one queued expectation per rising edge, sampled 1 time unit later.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (rezultat !== e.r) begin
          failures++;
          $display("FAIL %s rezultat: got %h expected %h", e.tag, rezultat, e.r);
        end
        checks++;
        if (rest_rezultat !== e.rest) begin
          failures++;
          $display("FAIL %s rest_rezultat: got %h expected %h", e.tag, rest_rezultat, e.rest);
        end
        checks++;
        if (zero !== e.z) begin
          failures++;
          $display("FAIL %s zero: got %0b expected %0b", e.tag, zero, e.z);
        end
      end
    end
  end

  // Stimulus sequence.
  initial begin
    logic [31:0] ra, rb;
    int          rop;
    checks    = 0;
    failures  = 0;
    stim_done = 1'b0;
    rst_n     = 1'b0;
    A         = 32'd7;
    B         = 32'd3;
    operatie  = 4'd0;

    // Reset held for two cycles with a live ADD on the inputs.
    issue("reset0", 1'b0, 32'd7, 32'd3, 4'd0, 32'd0, 32'd0, 1'b1);
    issue("reset1", 1'b0, 32'd7, 32'd3, 4'd0, 32'd0, 32'd0, 1'b1);

    // Basic ops, A=100 B=7, back to back.
    issue("add", 1'b1, 32'd100, 32'd7, 4'd0, 32'd107, 32'd0, 1'b0);
    issue("sub", 1'b1, 32'd100, 32'd7, 4'd1, 32'd93,  32'd0, 1'b0);
    issue("mul", 1'b1, 32'd100, 32'd7, 4'd2, 32'd700, 32'd0, 1'b0);
    issue("div", 1'b1, 32'd100, 32'd7, 4'd3, 32'd14,  32'd2, 1'b0);
    issue("and", 1'b1, 32'd100, 32'd7, 4'd4, 32'd4,   32'd0, 1'b0);
    issue("or",  1'b1, 32'd100, 32'd7, 4'd5, 32'd103, 32'd0, 1'b0);
    issue("xor", 1'b1, 32'd100, 32'd7, 4'd6, 32'd99,  32'd0, 1'b0);

    // Shifts and zero flag.
    issue("shl",      1'b1, 32'd50, 32'd3,  4'd7, 32'd400, 32'd0, 1'b0);
    issue("shr",      1'b1, 32'd50, 32'd3,  4'd8, 32'd6,   32'd0, 1'b0);
    issue("sub_zero", 1'b1, 32'd5,  32'd5,  4'd1, 32'd0,   32'd0, 1'b1);
    issue("shl_32",   1'b1, 32'd1,  32'd32, 4'd7, 32'd0,   32'd0, 1'b1);
    issue("shr_big",  1'b1, 32'hFFFF_FFFF, 32'd40, 4'd8, 32'd0, 32'd0, 1'b1);
    issue("shl_31",   1'b1, 32'd3,  32'd31, 4'd7, 32'h8000_0000, 32'd0, 1'b0);

    // Boundary values.
    issue("sub_wrap", 1'b1, 32'd3, 32'd5, 4'd1, 32'hFFFF_FFFE, 32'd0, 1'b0);
    issue("add_wrap", 1'b1, 32'hFFFF_FFFF, 32'd1, 4'd0, 32'd0, 32'd0, 1'b1);
    issue("div0",     1'b1, 32'd9, 32'd0, 4'd3, 32'hFFFF_FFFF, 32'd9, 1'b0);
    issue("mul_wrap", 1'b1, 32'h0001_0000, 32'h0001_0000, 4'd2, 32'd0, 32'd0, 1'b1);
    issue("div_rem_nz_zero", 1'b1, 32'd3, 32'd7, 4'd3, 32'd0, 32'd3, 1'b1);

    // Undefined ops.
    issue("op12", 1'b1, 32'd10, 32'd2, 4'd12, 32'd0, 32'd0, 1'b1);
    issue("op9",  1'b1, 32'd10, 32'd2, 4'd9,  32'd0, 32'd0, 1'b1);
    issue("op15", 1'b1, 32'd10, 32'd2, 4'd15, 32'd0, 32'd0, 1'b1);

    // Reset overriding an operation mid-stream, then immediate recovery.
    issue("mid_reset",   1'b0, 32'd100, 32'd7, 4'd0, 32'd0,   32'd0, 1'b1);
    issue("post_reset",  1'b1, 32'd100, 32'd7, 4'd0, 32'd107, 32'd0, 1'b0);

    // Randomized stream, inputs change every cycle.
    for (int i = 0; i < 300; i++) begin
      rop = int'($urandom_range(8, 0));
      if (rop == 7 || rop == 8) begin
        ra = 32'($urandom_range(100, 1));
        rb = 32'($urandom_range(3, 1));
      end else begin
        ra = 32'($urandom_range(100, 1));
        rb = 32'($urandom_range(ra, 1));
      end
      issue_model(ra, rb, rop);
    end

    // Let the last expectation drain.
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    stim_done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
